// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax normalisation stage.
package softmax_pkg;

    localparam int unsigned Q_W         = 16;
    localparam int unsigned MAX_ROW_DEF = 64;
    localparam int unsigned ROW_PTR_W   = $clog2(MAX_ROW_DEF);
    localparam int unsigned ROUND_HALF  = 1 << (Q_W - 1);

    typedef logic [Q_W-1:0] q0_16_t;

    typedef enum logic [1:0] {
        FILL,
        WAIT_RECIP,
        DRAIN
    } norm_state_t;

endpackage

// File: rtl/softmax_row_buffer.sv
// Row storage: one write port, one registered read port with read enable.
module softmax_row_buffer
    import softmax_pkg::*;
#(
    parameter int unsigned WIDTH  = Q_W,
    parameter int unsigned DEPTH  = MAX_ROW_DEF,
    parameter int unsigned ADDR_W = ROW_PTR_W
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write on demand; read data holds whenever the read enable is low.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/softmax_normalize.sv
// Buffers one row of exponentials, then streams each one scaled by 1/sum.
module softmax_normalize
    import softmax_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = Q_W,
    parameter int unsigned MAX_ROW   = MAX_ROW_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_exp_valid,
    input  logic [BIT_WIDTH-1:0] i_exp,
    input  logic                 i_exp_last,
    output logic                 o_exp_ready,
    input  logic                 i_recip_valid,
    input  logic [BIT_WIDTH-1:0] i_recip,
    output logic                 o_valid,
    output logic [BIT_WIDTH-1:0] o_prob,
    output logic                 o_last,
    input  logic                 i_ready,
    output logic                 o_err
);

    localparam int unsigned PTR_W  = $clog2(MAX_ROW);
    localparam int unsigned LEN_W  = PTR_W + 1;
    localparam int unsigned PROD_W = 2 * BIT_WIDTH;
    localparam logic [PROD_W-1:0] RND = (BIT_WIDTH == Q_W) ? PROD_W'(ROUND_HALF)
                                                           : PROD_W'(1) << (BIT_WIDTH - 1);

    norm_state_t          state_q, state_d;
    logic [PTR_W-1:0]     count_q, count_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [BIT_WIDTH-1:0] recip_q, recip_d;
    logic                 err_q, err_d;
    logic                 exp_ready_q, exp_ready_d;

    logic                 accept_c, stall_c, issue_c, idx_last_c, row_done_c;
    logic [PTR_W-1:0]     rd_addr_c;
    logic [BIT_WIDTH-1:0] rd_data;

    logic                 s1_v_q, s1_last_q, s2_v_q, s2_last_q;
    logic [PROD_W-1:0]    prod_q;
    logic                 valid_q, last_q;
    logic [BIT_WIDTH-1:0] prob_q;

    assign accept_c   = (state_q == FILL) && i_exp_valid && exp_ready_q;
    assign stall_c    = valid_q && !i_ready;
    assign row_done_c = valid_q && i_ready && last_q;
    // Element 0 is fetched on the recip cycle itself so the first result lands three cycles later.
    assign rd_addr_c  = (state_q == DRAIN) ? rd_ptr_q[PTR_W-1:0] : '0;
    assign issue_c    = ((state_q == WAIT_RECIP) && i_recip_valid) ||
                        ((state_q == DRAIN) && !stall_c && (rd_ptr_q < len_q));
    assign idx_last_c = ({1'b0, rd_addr_c} == (len_q - LEN_W'(1)));

    // Control state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= FILL;
            count_q     <= '0;
            len_q       <= '0;
            rd_ptr_q    <= '0;
            recip_q     <= '0;
            err_q       <= 1'b0;
            exp_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            rd_ptr_q    <= rd_ptr_d;
            recip_q     <= recip_d;
            err_q       <= err_d;
            exp_ready_q <= exp_ready_d;
        end
    end

    // Next-state: fill the row, wait for 1/sum, drain until the last result is taken.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        recip_d  = recip_q;
        err_d    = err_q;
        case (state_q)
            FILL: begin
                if (accept_c) begin
                    count_d = count_q + PTR_W'(1);
                    if (i_exp_last || (count_q == PTR_W'(MAX_ROW - 1))) begin
                        len_d   = LEN_W'(count_q) + LEN_W'(1);
                        count_d = '0;
                        state_d = WAIT_RECIP;
                        if (!i_exp_last) begin
                            err_d = 1'b1;
                        end
                    end
                end
                if (i_recip_valid) begin
                    err_d = 1'b1;
                end
            end
            WAIT_RECIP: begin
                if (i_recip_valid) begin
                    recip_d  = i_recip;
                    rd_ptr_d = LEN_W'(1);
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (issue_c) begin
                    rd_ptr_d = rd_ptr_q + LEN_W'(1);
                end
                if (i_recip_valid) begin
                    err_d = 1'b1;
                end
                if (row_done_c) begin
                    count_d = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        exp_ready_d = (state_d == FILL);
    end

    softmax_row_buffer #(
        .WIDTH (BIT_WIDTH),
        .DEPTH (MAX_ROW),
        .ADDR_W(PTR_W)
    ) u_row_buffer (
        .i_clk    (i_clk),
        .i_wr_en  (accept_c),
        .i_wr_addr(count_q),
        .i_wr_data(i_exp),
        .i_rd_en  (issue_c),
        .i_rd_addr(rd_addr_c),
        .o_rd_data(rd_data)
    );

    // Read -> multiply -> round/output pipeline; the whole chain freezes on backpressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_last_q <= 1'b0;
            prod_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            prob_q    <= '0;
        end else if (!stall_c) begin
            s1_v_q    <= issue_c;
            s1_last_q <= issue_c && idx_last_c;
            s2_v_q    <= s1_v_q;
            s2_last_q <= s1_last_q;
            prod_q    <= PROD_W'(rd_data) * PROD_W'(recip_q);
            valid_q   <= s2_v_q;
            last_q    <= s2_last_q;
            prob_q    <= BIT_WIDTH'((prod_q + RND) >> BIT_WIDTH);
        end
    end

    assign o_exp_ready = exp_ready_q;
    assign o_valid     = valid_q;
    assign o_prob      = prob_q;
    assign o_last      = last_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_softmax_normalize.sv
// Bench for softmax_normalize: directed rows plus random rows against a queue model.
module tb_softmax_normalize;
    import softmax_pkg::*;

    localparam int unsigned BW = 16;
    localparam int unsigned MR = 64;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_exp_valid = 1'b0;
    logic [BW-1:0] i_exp = '0;
    logic          i_exp_last = 1'b0;
    logic          i_recip_valid = 1'b0;
    logic [BW-1:0] i_recip = '0;
    logic          i_ready = 1'b1;
    logic          o_exp_ready, o_valid, o_last, o_err;
    logic [BW-1:0] o_prob;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_count = 0;
    int last_hs_edge = -1;
    int acc_edge = 0;
    int rdy_mode = 0;
    int pidx = 0;

    q0_16_t exp_prob [$];
    bit     exp_last [$];
    q0_16_t got      [$];
    q0_16_t row_q    [$];

    bit     stall_prev = 1'b0;
    q0_16_t held_prob = '0;
    logic   held_last = 1'b0;

    softmax_normalize #(.BIT_WIDTH(BW), .MAX_ROW(MR)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_exp_valid  (i_exp_valid),
        .i_exp        (i_exp),
        .i_exp_last   (i_exp_last),
        .o_exp_ready  (o_exp_ready),
        .i_recip_valid(i_recip_valid),
        .i_recip      (i_recip),
        .o_valid      (o_valid),
        .o_prob       (o_prob),
        .o_last       (o_last),
        .i_ready      (i_ready),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: round-half-up of the Q0.32 product back to Q0.16.
    function automatic q0_16_t ref_prob(input q0_16_t e, input q0_16_t r);
        logic [31:0] p;
        p = 32'(e) * 32'(r) + 32'(ROUND_HALF);
        return p[31:16];
    endfunction

    // Downstream ready: always, 1-0-0-1 pattern, or random.
    always @(posedge i_clk) begin
        #1;
        case (rdy_mode)
            0: i_ready = 1'b1;
            1: begin
                i_ready = (pidx == 0) || (pidx == 3);
                pidx = (pidx + 1) % 4;
            end
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output checker: every handshake against the model, every stall for stability.
    always @(negedge i_clk) begin
        if (i_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_prob", 32'(o_prob), 32'(held_prob));
                chk("stall_last", 32'(o_last), 32'(held_last));
            end
            if (o_valid && i_ready) begin
                hs_count++;
                if (exp_prob.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_output: got prob %h with nothing expected", o_prob);
                end else begin
                    chk("prob", 32'(o_prob), 32'(exp_prob.pop_front()));
                    chk("last", 32'(o_last), 32'(exp_last.pop_front()));
                    got.push_back(o_prob);
                    if (o_last) last_hs_edge = cyc + 1;
                end
            end
            stall_prev = o_valid && !i_ready;
            held_prob  = o_prob;
            held_last  = o_last;
        end
    end

    // Present one element and hold it until accepted; call at posedge+1 or while not ready.
    task automatic send_elem(input q0_16_t d, input logic last);
        int n;
        n = 0;
        i_exp_valid = 1'b1;
        i_exp       = d;
        i_exp_last  = last;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_exp_ready && n < 500);
        acc_edge = cyc + 1;
        if (!o_exp_ready) chk("exp_accept_timeout", 32'(o_exp_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_exp_valid = 1'b0;
        i_exp_last  = 1'b0;
    endtask

    task automatic send_row(input bit with_last);
        @(posedge i_clk);
        #1;
        foreach (row_q[i]) send_elem(row_q[i], with_last && (i == row_q.size() - 1));
    endtask

    task automatic model_push(input q0_16_t r);
        int n;
        n = (row_q.size() > int'(MR)) ? int'(MR) : row_q.size();
        for (int i = 0; i < n; i++) begin
            exp_prob.push_back(ref_prob(row_q[i], r));
            exp_last.push_back(i == n - 1);
        end
    endtask

    task automatic pulse_recip(input q0_16_t r);
        i_recip_valid = 1'b1;
        i_recip       = r;
        @(posedge i_clk);
        #1;
        i_recip_valid = 1'b0;
    endtask

    task automatic send_recip(input q0_16_t r);
        pulse_recip(r);
        @(negedge i_clk);
        chk("latency_c1", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        chk("latency_c2", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        chk("latency_c3", 32'(o_valid), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_prob.size() != 0 || o_valid) && n < 3000) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk({name, "_drained"}, 32'(exp_prob.size()), 32'd0);
        chk({name, "_idle"}, 32'(o_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        exp_prob.delete();
        exp_last.delete();
        got.delete();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        int base;
        int n;
        q0_16_t w3 [3];

        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_exp_ready", 32'(o_exp_ready), 32'd1);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_prob", 32'(o_prob), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);

        chk("pin_quarter", 32'(ref_prob(16'h4000, 16'h4000)), 32'h1000);
        chk("pin_half_up", 32'(ref_prob(16'h0003, 16'h8000)), 32'h0002);
        chk("pin_max", 32'(ref_prob(16'hFFFF, 16'hFFFF)), 32'hFFFE);

        // Row of four equal exps.
        rdy_mode = 0;
        row_q = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        send_row(1'b1);
        model_push(16'h4000);
        got.delete();
        send_recip(16'h4000);
        wait_drain("t1");
        chk("t1_count", 32'(got.size()), 32'd4);
        foreach (got[i]) chk("t1_value", 32'(got[i]), 32'h1000);

        // Rounding cases.
        row_q = '{16'h0001, 16'h0003, 16'hFFFF};
        send_row(1'b1);
        model_push(16'h8000);
        got.delete();
        send_recip(16'h8000);
        wait_drain("t2a");
        w3 = '{16'h0001, 16'h0002, 16'h8000};
        chk("t2a_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("t2a_value", 32'(got[i]), 32'(w3[i]));

        row_q = '{16'hFFFF};
        send_row(1'b1);
        model_push(16'hFFFF);
        got.delete();
        send_recip(16'hFFFF);
        wait_drain("t2b");
        chk("t2b_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("t2b_value", 32'(got[0]), 32'hFFFE);

        // Backpressure 1,0,0,1.
        row_q.delete();
        for (int k = 1; k <= 8; k++) row_q.push_back(16'(k * 16'h1000));
        send_row(1'b1);
        model_push(16'h2000);
        got.delete();
        rdy_mode = 1;
        pidx = 0;
        send_recip(16'h2000);
        wait_drain("t3");
        rdy_mode = 0;
        chk("t3_count", 32'(got.size()), 32'd8);
        foreach (got[i]) chk("t3_value", 32'(got[i]), 32'((i + 1) * 16'h0200));
        chk("t3_no_err", 32'(o_err), 32'd0);

        // Recip during FILL, then back-to-back rows.
        row_q = '{16'h1000, 16'h2000};
        send_row(1'b0);
        pulse_recip(16'h7777);
        @(negedge i_clk);
        chk("fill_recip_err", 32'(o_err), 32'd1);
        chk("fill_recip_still_fill", 32'(o_exp_ready), 32'd1);
        row_q = '{16'h3000};
        send_row(1'b1);
        row_q = '{16'h1000, 16'h2000, 16'h3000};
        model_push(16'h8000);
        got.delete();
        send_recip(16'h8000);
        send_elem(16'h5000, 1'b0);
        chk("b2b_accept_edge", 32'(acc_edge), 32'(last_hs_edge + 1));
        chk("t5a_count", 32'(got.size()), 32'd3);
        got.delete();
        send_elem(16'h6000, 1'b1);
        row_q = '{16'h5000, 16'h6000};
        model_push(16'hA000);
        send_recip(16'hA000);
        wait_drain("t5b");
        chk("t5b_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("t5b_v0", 32'(got[0]), 32'h3200);
            chk("t5b_v1", 32'(got[1]), 32'h3C00);
        end

        // Overflow: 64 elements and no last.
        do_reset();
        chk("pre_ovf_err", 32'(o_err), 32'd0);
        row_q.delete();
        for (int k = 0; k < int'(MR); k++) row_q.push_back(16'($urandom));
        send_row(1'b0);
        @(negedge i_clk);
        chk("ovf_ready_low", 32'(o_exp_ready), 32'd0);
        chk("ovf_err", 32'(o_err), 32'd1);
        model_push(16'h0400);
        got.delete();
        send_recip(16'h0400);
        wait_drain("t4");
        chk("t4_count", 32'(got.size()), 32'd64);

        // Random rows under random backpressure.
        rdy_mode = 2;
        for (int r = 0; r < 8; r++) begin
            q0_16_t rc;
            row_q.delete();
            n = int'($urandom_range(1, 20));
            for (int k = 0; k < n; k++) row_q.push_back(16'($urandom));
            rc = 16'($urandom);
            send_row(1'b1);
            model_push(rc);
            send_recip(rc);
            wait_drain("rand");
        end
        rdy_mode = 0;

        // Reset in the middle of a drain.
        row_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        send_row(1'b1);
        model_push(16'h9000);
        base = hs_count;
        send_recip(16'h9000);
        n = 0;
        while (hs_count < base + 2 && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("t6_two_out", 32'(hs_count - base), 32'd2);
        i_rst = 1'b1;
        exp_prob.delete();
        exp_last.delete();
        got.delete();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("t6_valid", 32'(o_valid), 32'd0);
        chk("t6_exp_ready", 32'(o_exp_ready), 32'd1);
        chk("t6_err", 32'(o_err), 32'd0);
        row_q = '{16'h8000, 16'h4000};
        send_row(1'b1);
        model_push(16'hC000);
        send_recip(16'hC000);
        wait_drain("t6");
        chk("t6_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("t6_v0", 32'(got[0]), 32'h6000);
            chk("t6_v1", 32'(got[1]), 32'h3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
